sync_down_counter_jk: RTL and testbench

Synchronous down counter built from per-bit JK toggle cells. It complements the existing synchronous up counter. It supports parallel load, count enable, a configurable modulus, and two modes: continuous (wrap) and one-shot (halt at zero). Intended uses are timer and delay blocks, and cascading with the up counter for up/down counting stages.

---
 rtl/sync_down_counter_jk.sv | 91 +++++++++
 tb/tb_sync_down_counter_jk.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sync_down_counter_jk.sv
// Synchronous modulo-MOD down counter built from per-bit JK cells, with parallel load,
// count enable and a one-shot mode that halts at zero until the next load or reset.
module sync_down_counter_jk #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             borrow,
  output logic             done
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD - 1);

  typedef enum logic {StRun, StHalt} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] toggle, target, j, k;
  logic             borrow_q, borrow_d;
  logic             force_val, count;

  assign zero = (q_q == '0);

  always_comb begin
    state_d   = state_q;
    borrow_d  = 1'b0;
    force_val = 1'b0;
    count     = 1'b0;
    target    = (load_val > MaxVal) ? MaxVal : load_val;

    if (load) begin
      force_val = 1'b1;
      state_d   = StRun;
    end else if (state_q == StRun && en) begin
      if (!zero) begin
        count = 1'b1;
      end else if (!mode) begin
        force_val = 1'b1;
        target    = MaxVal;
        borrow_d  = 1'b1;
      end else begin
        state_d = StHalt;
      end
    end

    // Bit i toggles on a decrement when every lower bit is already zero.
    toggle[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      toggle[i] = toggle[i-1] & ~q_q[i-1];
    end

    // Load and wrap drive J/K as set/reset to force the target value into the cells.
    for (int i = 0; i < WIDTH; i++) begin
      if (force_val) begin
        j[i] = target[i];
        k[i] = ~target[i];
      end else if (count) begin
        j[i] = toggle[i];
        k[i] = toggle[i];
      end else begin
        j[i] = 1'b0;
        k[i] = 1'b0;
      end
      q_d[i] = (j[i] & ~q_q[i]) | (~k[i] & q_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q      <= MaxVal;
      state_q  <= StRun;
      borrow_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      state_q  <= state_d;
      borrow_q <= borrow_d;
    end
  end

  assign q      = q_q;
  assign borrow = borrow_q;
  assign done   = (state_q == StHalt);

endmodule

// File: tb/tb_sync_down_counter_jk.sv
// Bench for sync_down_counter_jk: three instances (MOD 16, 10, 2) share stimulus and are
// compared against an arithmetic reference model, plus a fixed vector table and corner sequences.
module tb_sync_down_counter_jk;

  logic       clk = 1'b0;
  logic       reset, en, load, mode;
  logic [3:0] load_val;

  logic [3:0] q16, q10, q2;
  logic       z16, z10, z2, b16, b10, b2, d16, d10, d2;
  logic [3:0] dq[3];
  logic       dz[3], db[3], dd[3];

  int n_checks = 0;
  int n_errors = 0;

  int mods[3] = '{16, 10, 2};
  int m_q[3];
  bit m_halt[3];
  bit m_borrow[3];

  always #5 clk = ~clk;

  sync_down_counter_jk #(.WIDTH(4), .MOD(16)) dut16 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val), .mode(mode),
    .q(q16), .zero(z16), .borrow(b16), .done(d16)
  );
  sync_down_counter_jk #(.WIDTH(4), .MOD(10)) dut10 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val), .mode(mode),
    .q(q10), .zero(z10), .borrow(b10), .done(d10)
  );
  sync_down_counter_jk #(.WIDTH(4), .MOD(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val), .mode(mode),
    .q(q2), .zero(z2), .borrow(b2), .done(d2)
  );

  assign dq[0] = q16;
  assign dq[1] = q10;
  assign dq[2] = q2;
  assign dz[0] = z16;
  assign dz[1] = z10;
  assign dz[2] = z2;
  assign db[0] = b16;
  assign db[1] = b10;
  assign db[2] = b2;
  assign dd[0] = d16;
  assign dd[1] = d10;
  assign dd[2] = d2;

  typedef struct {
    logic       r, e, l;
    logic [3:0] lv;
    logic       m;
    int         q;
    logic       z, b, d;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: next state from the behavioural rules, in priority order.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_q[i] = mods[i] - 1; m_halt[i] = 0; m_borrow[i] = 0;
      end else if (load) begin
        m_q[i] = (int'(load_val) >= mods[i]) ? mods[i] - 1 : int'(load_val);
        m_halt[i] = 0; m_borrow[i] = 0;
      end else if (m_halt[i] || !en) begin
        m_borrow[i] = 0;
      end else if (m_q[i] > 0) begin
        m_q[i] = m_q[i] - 1; m_borrow[i] = 0;
      end else if (!mode) begin
        m_q[i] = mods[i] - 1; m_borrow[i] = 1;
      end else begin
        m_halt[i] = 1; m_borrow[i] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s mod%0d q", tag, mods[i]), int'(dq[i]), m_q[i]);
      chk($sformatf("%s mod%0d zero", tag, mods[i]), int'(dz[i]), int'(m_q[i] == 0));
      chk($sformatf("%s mod%0d borrow", tag, mods[i]), int'(db[i]), int'(m_borrow[i]));
      chk($sformatf("%s mod%0d done", tag, mods[i]), int'(dd[i]), int'(m_halt[i]));
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic l, input logic [3:0] lv,
                       input logic m);
    reset = r; en = e; load = l; load_val = lv; mode = m;
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; load_val = 4'd0; mode = 1'b0;
    #1;

    //            r  e  l  lv m   q  z  b  d
    vecs[0]  = '{1, 0, 0, 0, 0, 15, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, 14, 0, 0, 0};
    vecs[2]  = '{0, 0, 1, 1, 0,  1, 0, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 0,  0, 1, 0, 0};
    vecs[4]  = '{0, 1, 0, 0, 0, 15, 0, 1, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 15, 0, 0, 0};
    vecs[6]  = '{0, 1, 1, 2, 0,  2, 0, 0, 0};
    vecs[7]  = '{0, 1, 0, 0, 1,  1, 0, 0, 0};
    vecs[8]  = '{0, 1, 0, 0, 1,  0, 1, 0, 0};
    vecs[9]  = '{0, 1, 0, 0, 1,  0, 1, 0, 1};
    vecs[10] = '{0, 1, 0, 0, 0,  0, 1, 0, 1};
    vecs[11] = '{0, 1, 1, 5, 1,  5, 0, 0, 0};
    vecs[12] = '{0, 1, 0, 0, 1,  4, 0, 0, 0};
    vecs[13] = '{1, 1, 1, 3, 1, 15, 0, 0, 0};
    vecs[14] = '{0, 1, 0, 0, 0, 14, 0, 0, 0};
    vecs[15] = '{0, 0, 0, 0, 0, 14, 0, 0, 0};

    for (int v = 0; v < 16; v++) begin
      drive(vecs[v].r, vecs[v].e, vecs[v].l, vecs[v].lv, vecs[v].m);
      chk($sformatf("vec%0d q", v), int'(q16), vecs[v].q);
      chk($sformatf("vec%0d zero", v), int'(z16), int'(vecs[v].z));
      chk($sformatf("vec%0d borrow", v), int'(b16), int'(vecs[v].b));
      chk($sformatf("vec%0d done", v), int'(d16), int'(vecs[v].d));
      check_all($sformatf("vec%0d", v));
    end

    // Full wrap on MOD=16: 15 down to 0 then back to 15 with a single borrow pulse.
    drive(1, 0, 0, 0, 0);
    for (int c = 0; c < 17; c++) begin
      drive(0, 1, 0, 0, 0);
      chk($sformatf("wrap16 c%0d q", c), int'(q16), (c < 15) ? 14 - c : (c == 15 ? 15 : 14));
      chk($sformatf("wrap16 c%0d borrow", c), int'(b16), int'(c == 15));
    end

    // Back-to-back wraps with a modulus of 2: borrow every other cycle.
    drive(1, 0, 0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      drive(0, 1, 0, 0, 0);
      chk($sformatf("mod2 c%0d q", c), int'(q2), c % 2);
      chk($sformatf("mod2 c%0d borrow", c), int'(b2), c % 2);
    end

    // Load of 12 clamps to 9 on the modulus-10 instance, which never exceeds 9.
    drive(0, 0, 1, 4'd12, 0);
    chk("mod10 clamp", int'(q10), 9);
    for (int c = 0; c < 25; c++) begin
      drive(0, 1, 0, 0, 0);
      chk($sformatf("mod10 range c%0d", c), int'(q10 <= 4'd9), 1);
      check_all("mod10 run");
    end

    // en toggling from 4: 3,3,2,2 with no borrow.
    drive(0, 0, 1, 4'd4, 0);
    for (int c = 0; c < 4; c++) begin
      drive(0, (c % 2 == 0), 0, 0, 0);
      chk($sformatf("entog c%0d q", c), int'(q16), (c < 2) ? 3 : 2);
      chk($sformatf("entog c%0d borrow", c), int'(b16), 0);
    end

    // Reset out of HALT, then mid-count at 6.
    drive(0, 0, 1, 4'd0, 1);
    drive(0, 1, 0, 0, 1);
    chk("halt done", int'(d16), 1);
    drive(1, 1, 0, 0, 1);
    chk("halt reset q", int'(q16), 15);
    chk("halt reset done", int'(d16), 0);
    drive(0, 0, 1, 4'd6, 0);
    drive(1, 1, 0, 0, 0);
    chk("mid reset q", int'(q16), 15);
    chk("mid reset borrow", int'(b16), 0);
    drive(0, 1, 0, 0, 0);
    chk("resume q", int'(q16), 14);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      drive(($urandom_range(49) == 0), ($urandom_range(3) != 0), ($urandom_range(11) == 0),
            4'($urandom_range(15)), ($urandom_range(3) == 0));
      check_all($sformatf("rand%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
